// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit, DEPTH-stage register pipeline with per-stage valid
// bits, global stall, flush, a selectable tap output and an occupancy count.
// A word sampled on an enabled edge leaves on q after DEPTH enabled edges.
module dff_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              TW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int              CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             enable,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic [TW-1:0]    tap_sel,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [WIDTH-1:0] tap_q,
    output logic             tap_valid,
    output logic [CW-1:0]    count
);

    // Stage registers and their next-state values
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    // What each stage would load on an enabled edge: din for stage 0,
    // the previous stage otherwise
    logic [WIDTH-1:0] shift_data [DEPTH];
    logic [DEPTH-1:0] shift_v;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage_in
            if (gi == 0) begin : g_head
                assign shift_data[gi] = din;
                assign shift_v[gi]    = din_valid;
            end else begin : g_body
                assign shift_data[gi] = data_q[gi-1];
                assign shift_v[gi]    = v_q[gi-1];
            end
        end
    endgenerate

    // Next state: flush drops all valid bits but leaves data in place and
    // does not capture din; otherwise shift on enable, hold when stalled
    always_comb begin
        data_d  = data_q;
        v_d     = v_q;
        count_d = count_q;
        if (flush) begin
            v_d     = '0;
            count_d = '0;
        end else if (enable) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = shift_data[i];
            end
            v_d     = shift_v;
            // One word may enter and one may leave on the same edge; the
            // counter tracks popcount(v) so it never exceeds DEPTH
            count_d = count_q + CW'(din_valid) - CW'(v_q[DEPTH-1]);
        end
    end

    // State register; clear overrides flush and enable
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RESET_VAL;
            end
            v_q     <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
            v_q     <= v_d;
            count_q <= count_d;
        end
    end

    // Tap mux; indices past the last stage read as an empty reset stage
    always_comb begin
        tap_q     = RESET_VAL;
        tap_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == TW'(i)) begin
                tap_q     = data_q[i];
                tap_valid = v_q[i];
            end
        end
    end

    assign q       = data_q[DEPTH-1];
    assign q_valid = v_q[DEPTH-1];
    assign count   = count_q;

endmodule
